bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Parametrised multi-digit radix-N up/down counter with enable, synchronous clear, parallel load and cascade carry. It is the general successor to the team's single-digit decade counter. Use it for event tallies, display drivers and timing dividers where a multi-digit decimal (or other radix) count is needed. The block sits between the front-end event strobes and the display/readout logic, and can be chained through its Carry output.

## Interface
- DIGITS, 4, number of digits; each digit is 4 bits wide (1..8).
- RADIX, 10, modulus of every digit (2..16); each digit counts 0..RADIX-1.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low; clears all state.
- Count  input  1  count enable; one step per rising Clock edge while high.
- Up  input  1  direction; 1 = increment, 0 = decrement.
- Clear  input  1  synchronous clear to zero.
- Load  input  1  synchronous parallel load.
- LoadValue  input  4*DIGITS  load data; digit k in bits [4k+3:4k].
- Value  output  4*DIGITS  current count; digit 0 is least significant.
- Carry  output  1  combinational terminal-count strobe, for cascading.
- Wrapped  output  1  sticky flag: a terminal event has occurred.

## Operation
- Reset is asynchronous, active-low; clock is Clock. Reset forces Value = 0 and Wrapped = 0. Carry is then 0 because it is decoded from Value.
- Per-edge priority: Clear > Load > Count. The lower actions are ignored in any cycle where a higher one is active.
- Clear: Value <= 0, Wrapped <= 0.
- Load: every digit takes LoadValue. A digit value >= RADIX is loaded as 0. Wrapped <= 0.
- Count with Up=1: digit 0 increments. Digit k increments only when all lower digits equal RADIX-1. A digit at RADIX-1 that increments wraps to 0.
- Count with Up=0: digit 0 decrements. Digit k decrements only when all lower digits equal 0. A digit at 0 that decrements wraps to RADIX-1.
- Terminal state: all digits RADIX-1 when Up=1; all digits 0 when Up=0.
- Carry = Count & !Clear & !Load & (Value is in the terminal state for the current Up).
- Wrapped <= 1 on any edge where Carry=1. It holds until Clear, Load or Reset.
- Count=0 with no Clear or Load: Value and Wrapped hold.
- Changing Up between edges is legal. Direction is sampled each edge, with no pipeline penalty.

## Timing
- Value updates on the Clock edge that samples Count, Clear or Load. It is visible one cycle after the request, with no extra latency.
- Carry is combinational in the same cycle as the terminal step. Chaining instance B's Count to instance A's Carry makes B step on the same edge that A wraps.
- Reset deasserting mid-count: the first edge after release counts from 0.
- Reset asserting mid-cycle zeroes the outputs immediately, independent of Clock.
- Clear and Load in the same cycle: Clear wins and Value = 0.
- Load and Count in the same cycle: the load value is taken and no step is applied. Carry = 0.

## Configuration
- Macro: BCD_UPDOWN_COUNTER_SAT_EN.
- Defined: saturating mode. A Count step in the terminal state leaves Value unchanged; it holds at all-(RADIX-1) going up and at 0 going down. Carry still pulses and Wrapped still sets, which signals the overflow attempt. All other behaviour is unchanged.
- Undefined (default): wrap-around mode as described in Operation. From the up terminal state the next value is 0; from the down terminal state it is all-(RADIX-1).

## Test plan
All scenarios use DIGITS=2 and RADIX=10 unless stated.
- Reset low, then high, then Count=1, Up=1 for 12 edges -> Value goes 00, 01 … 09, 10, 11, 12, Carry=0, Wrapped=0.
- Load 0x98, then Count=1, Up=1 for 2 edges -> Value 99; Carry=1 during the step from 99; next Value 00 (with SAT_EN: 99) and Wrapped=1.
- Load 0x01, then Count=1, Up=0 for 3 edges -> Value 00, then 99 (with SAT_EN: holds 00). Carry=1 on the step from 00. Wrapped=1.
- Load 0xAF -> Value 00 (both digits invalid). Load 0x5C -> Value 50. Clear and Load together with LoadValue 0x42 -> Value 00.
- Two instances cascaded, B.Count = A.Carry, count 100 up-steps from 0 -> A=00, B=01; B steps on exactly the edge A goes 99 -> 00.
- Reset pulled low mid-count at Value 37, asynchronously between edges -> Value 00 and Wrapped 0 immediately, not waiting for an edge. After release, counting resumes 01, 02.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit radix-N up/down counter with clear, parallel load and cascade carry.
// Define BCD_UPDOWN_COUNTER_SAT_EN to saturate at the terminal state instead of wrapping.
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Count,
    input  logic                  Up,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadValue,
    output logic [4*DIGITS-1:0]   Value,
    output logic                  Carry,
    output logic                  Wrapped
);

    localparam int              W         = 4 * DIGITS;
    localparam logic [3:0]      DIGIT_MAX = 4'(RADIX - 1);
    localparam logic [4:0]      RADIX_5B  = 5'(RADIX);

    logic [W-1:0]       r_value;
    logic               r_wrapped;

    logic [DIGITS-1:0]  w_low_max;
    logic [DIGITS-1:0]  w_low_zero;
    logic               w_term_up;
    logic               w_term_down;
    logic               w_terminal;
    logic               w_carry;
    logic [W-1:0]       w_step_value;
    logic [W-1:0]       w_count_value;
    logic [W-1:0]       w_load_value;

    // w_low_max[k] / w_low_zero[k]: every digit below k sits at its up / down limit.
    always_comb begin : terminal_decode
        logic v_all_max;
        logic v_all_zero;
        // NOTE: every output of a combinational block gets a value on every path,
        // starting with a default, so no latch is inferred.
        v_all_max  = 1'b1;
        v_all_zero = 1'b1;
        w_low_max  = '0;
        w_low_zero = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_low_max[k]  = v_all_max;
            w_low_zero[k] = v_all_zero;
            v_all_max     = v_all_max  & (r_value[4*k +: 4] == DIGIT_MAX);
            v_all_zero    = v_all_zero & (r_value[4*k +: 4] == 4'd0);
        end
        w_term_up   = v_all_max;
        w_term_down = v_all_zero;
    end

    always_comb begin : step_logic
        logic [3:0] v_digit;
        v_digit      = 4'd0;
        w_step_value = r_value;
        for (int k = 0; k < DIGITS; k++) begin
            v_digit = r_value[4*k +: 4];
            if (Up && w_low_max[k]) begin
                w_step_value[4*k +: 4] = (v_digit == DIGIT_MAX) ? 4'd0 : v_digit + 4'd1;
            end else if (!Up && w_low_zero[k]) begin
                w_step_value[4*k +: 4] = (v_digit == 4'd0) ? DIGIT_MAX : v_digit - 4'd1;
            end
        end
    end

    // Out-of-range load digits are forced to 0 so the count never leaves the radix.
    always_comb begin : load_sanitize
        logic [3:0] v_digit;
        v_digit      = 4'd0;
        w_load_value = '0;
        for (int k = 0; k < DIGITS; k++) begin
            v_digit = LoadValue[4*k +: 4];
            w_load_value[4*k +: 4] = ({1'b0, v_digit} >= RADIX_5B) ? 4'd0 : v_digit;
        end
    end

    assign w_terminal = Up ? w_term_up : w_term_down;
    assign w_carry    = Count & ~Clear & ~Load & w_terminal;

`ifdef BCD_UPDOWN_COUNTER_SAT_EN
    assign w_count_value = w_terminal ? r_value : w_step_value;
`else
    assign w_count_value = w_step_value;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, and all of them are cleared by the async reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_value   <= '0;
            r_wrapped <= 1'b0;
        end else if (Clear) begin
            r_value   <= '0;
            r_wrapped <= 1'b0;
        end else if (Load) begin
            r_value   <= w_load_value;
            r_wrapped <= 1'b0;
        end else if (Count) begin
            r_value <= w_count_value;
            if (w_carry) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign Value   = r_value;
    assign Carry   = w_carry;
    assign Wrapped = r_wrapped;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter (DIGITS=2, RADIX=10),
// including a two-instance cascade and an asynchronous reset check.
module tb_bcd_updown_counter;

    logic       Clock;
    logic       Reset;
    logic       Count;
    logic       Up;
    logic       Clear;
    logic       Load;
    logic [7:0] LoadValue;
    logic [7:0] Value;
    logic       Carry;
    logic       Wrapped;

    logic       c_count;
    logic [7:0] a_value;
    logic       a_carry;
    logic       a_wrapped;
    logic [7:0] b_value;
    logic       b_carry;
    logic       b_wrapped;

    int n_vec;
    int n_err;

`ifdef BCD_UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    bcd_updown_counter #(.DIGITS(2), .RADIX(10)) dut (
        .Clock(Clock), .Reset(Reset), .Count(Count), .Up(Up), .Clear(Clear),
        .Load(Load), .LoadValue(LoadValue), .Value(Value), .Carry(Carry),
        .Wrapped(Wrapped)
    );

    bcd_updown_counter #(.DIGITS(2), .RADIX(10)) cnt_a (
        .Clock(Clock), .Reset(Reset), .Count(c_count), .Up(1'b1), .Clear(1'b0),
        .Load(1'b0), .LoadValue(8'h00), .Value(a_value), .Carry(a_carry),
        .Wrapped(a_wrapped)
    );

    bcd_updown_counter #(.DIGITS(2), .RADIX(10)) cnt_b (
        .Clock(Clock), .Reset(Reset), .Count(a_carry), .Up(1'b1), .Clear(1'b0),
        .Load(1'b0), .LoadValue(8'h00), .Value(b_value), .Carry(b_carry),
        .Wrapped(b_wrapped)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic clr, input logic ld, input logic [7:0] lv,
                         input logic cnt, input logic up);
        Clear     = clr;
        Load      = ld;
        LoadValue = lv;
        Count     = cnt;
        Up        = up;
        #0;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        c_count = 1'b0;
        Reset   = 1'b0;
        #12;
        n_vec++; if (Value !== 8'h00) begin n_err++; $display("FAIL reset_value got %h want 00", Value); end
        n_vec++; if (Wrapped !== 1'b0) begin n_err++; $display("FAIL reset_wrapped got %b want 0", Wrapped); end
        n_vec++; if (Carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got %b want 0", Carry); end
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        n_vec++; if (Value !== 8'h00) begin n_err++; $display("FAIL reset_idle got %h want 00", Value); end
    endtask

    task automatic test_count_up();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            n_vec++; if (Carry !== 1'b0) begin n_err++; $display("FAIL up_carry step %0d got %b want 0", i, Carry); end
            tick();
            n_vec++; if (Value !== bcd2(i)) begin n_err++; $display("FAIL up_value step %0d got %h want %h", i, Value, bcd2(i)); end
            n_vec++; if (Wrapped !== 1'b0) begin n_err++; $display("FAIL up_wrapped step %0d got %b want 0", i, Wrapped); end
        end
    endtask

    task automatic test_wrap_up();
        logic [7:0] exp_v;
        exp_v = SAT ? 8'h99 : 8'h00;
        drive(1'b0, 1'b1, 8'h98, 1'b0, 1'b1);
        tick();
        n_vec++; if (Value !== 8'h98) begin n_err++; $display("FAIL wu_load got %h want 98", Value); end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_vec++; if (Carry !== 1'b0) begin n_err++; $display("FAIL wu_carry98 got %b want 0", Carry); end
        tick();
        n_vec++; if (Value !== 8'h99) begin n_err++; $display("FAIL wu_99 got %h want 99", Value); end
        n_vec++; if (Carry !== 1'b1) begin n_err++; $display("FAIL wu_carry99 got %b want 1", Carry); end
        tick();
        n_vec++; if (Value !== exp_v) begin n_err++; $display("FAIL wu_wrap got %h want %h", Value, exp_v); end
        n_vec++; if (Wrapped !== 1'b1) begin n_err++; $display("FAIL wu_wrapped got %b want 1", Wrapped); end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        n_vec++; if (Carry !== 1'b0) begin n_err++; $display("FAIL wu_idle_carry got %b want 0", Carry); end
        tick();
        n_vec++; if (Value !== exp_v) begin n_err++; $display("FAIL wu_hold got %h want %h", Value, exp_v); end
        n_vec++; if (Wrapped !== 1'b1) begin n_err++; $display("FAIL wu_hold_wrapped got %b want 1", Wrapped); end
        // Clear beats a simultaneous count and masks Carry.
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        n_vec++; if (Carry !== 1'b0) begin n_err++; $display("FAIL wu_clear_carry got %b want 0", Carry); end
        tick();
        n_vec++; if (Value !== 8'h00) begin n_err++; $display("FAIL wu_clear got %h want 00", Value); end
        n_vec++; if (Wrapped !== 1'b0) begin n_err++; $display("FAIL wu_clear_wrapped got %b want 0", Wrapped); end
    endtask

    task automatic test_wrap_down();
        drive(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        n_vec++; if (Value !== 8'h01) begin n_err++; $display("FAIL wd_load got %h want 01", Value); end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        n_vec++; if (Carry !== 1'b0) begin n_err++; $display("FAIL wd_carry01 got %b want 0", Carry); end
        tick();
        n_vec++; if (Value !== 8'h00) begin n_err++; $display("FAIL wd_00 got %h want 00", Value); end
        n_vec++; if (Carry !== 1'b1) begin n_err++; $display("FAIL wd_carry00 got %b want 1", Carry); end
        tick();
        n_vec++; if (Value !== (SAT ? 8'h00 : 8'h99)) begin n_err++; $display("FAIL wd_wrap got %h want %h", Value, SAT ? 8'h00 : 8'h99); end
        n_vec++; if (Wrapped !== 1'b1) begin n_err++; $display("FAIL wd_wrapped got %b want 1", Wrapped); end
        n_vec++; if (Carry !== SAT) begin n_err++; $display("FAIL wd_carry_after got %b want %b", Carry, SAT); end
        tick();
        n_vec++; if (Value !== (SAT ? 8'h00 : 8'h98)) begin n_err++; $display("FAIL wd_third got %h want %h", Value, SAT ? 8'h00 : 8'h98); end
        // Direction flips between edges with no penalty.
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        n_vec++; if (Value !== (SAT ? 8'h01 : 8'h99)) begin n_err++; $display("FAIL wd_flip got %h want %h", Value, SAT ? 8'h01 : 8'h99); end
        n_vec++; if (Wrapped !== 1'b1) begin n_err++; $display("FAIL wd_flip_wrapped got %b want 1", Wrapped); end
    endtask

    task automatic test_load();
        drive(1'b0, 1'b1, 8'hAF, 1'b0, 1'b1);
        tick();
        n_vec++; if (Value !== 8'h00) begin n_err++; $display("FAIL ld_AF got %h want 00", Value); end
        n_vec++; if (Wrapped !== 1'b0) begin n_err++; $display("FAIL ld_wrapped got %b want 0", Wrapped); end
        drive(1'b0, 1'b1, 8'h5C, 1'b0, 1'b1);
        tick();
        n_vec++; if (Value !== 8'h50) begin n_err++; $display("FAIL ld_5C got %h want 50", Value); end
        drive(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        tick();
        n_vec++; if (Value !== 8'h99) begin n_err++; $display("FAIL ld_99 got %h want 99", Value); end
        // Load with Count in the terminal state: load wins, no step, no Carry.
        drive(1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
        n_vec++; if (Carry !== 1'b0) begin n_err++; $display("FAIL ld_cnt_carry got %b want 0", Carry); end
        tick();
        n_vec++; if (Value !== 8'h42) begin n_err++; $display("FAIL ld_cnt got %h want 42", Value); end
        n_vec++; if (Wrapped !== 1'b0) begin n_err++; $display("FAIL ld_cnt_wrapped got %b want 0", Wrapped); end
        drive(1'b1, 1'b1, 8'h42, 1'b0, 1'b1);
        tick();
        n_vec++; if (Value !== 8'h00) begin n_err++; $display("FAIL clr_ld got %h want 00", Value); end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_cascade();
        logic [7:0] exp_a;
        c_count = 1'b1;
        for (int i = 0; i < 100; i++) begin
            n_vec++; if (a_carry !== (i == 99)) begin n_err++; $display("FAIL cas_carry step %0d got %b want %b", i, a_carry, (i == 99)); end
            tick();
            exp_a = (i == 99) ? (SAT ? 8'h99 : 8'h00) : bcd2(i + 1);
            n_vec++; if (a_value !== exp_a) begin n_err++; $display("FAIL cas_a step %0d got %h want %h", i, a_value, exp_a); end
            n_vec++; if (b_value !== ((i == 99) ? 8'h01 : 8'h00)) begin n_err++; $display("FAIL cas_b step %0d got %h want %h", i, b_value, (i == 99) ? 8'h01 : 8'h00); end
        end
        c_count = 1'b0;
    endtask

    task automatic test_async_reset();
        // Set Wrapped, then check that reset clears it without an edge.
        drive(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        n_vec++; if (Wrapped !== 1'b1) begin n_err++; $display("FAIL ar_pre_wrapped got %b want 1", Wrapped); end
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 37; i++) tick();
        n_vec++; if (Value !== 8'h37) begin n_err++; $display("FAIL ar_pre_value got %h want 37", Value); end
        #3;
        Reset = 1'b0;
        #1;
        n_vec++; if (Value !== 8'h00) begin n_err++; $display("FAIL ar_value got %h want 00", Value); end
        n_vec++; if (Wrapped !== 1'b0) begin n_err++; $display("FAIL ar_wrapped got %b want 0", Wrapped); end
        #1;
        Reset = 1'b1;
        tick();
        n_vec++; if (Value !== 8'h01) begin n_err++; $display("FAIL ar_resume1 got %h want 01", Value); end
        tick();
        n_vec++; if (Value !== 8'h02) begin n_err++; $display("FAIL ar_resume2 got %h want 02", Value); end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_load();
        test_cascade();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
